// File: rtl/mouse_action_ctrl.sv
// Turns mouse clicks into SELECT / MOVE / CANCEL game actions and hands
// them to the game logic over a valid/ready handshake.
module mouse_action_ctrl #(
    parameter int COLS         = 18,
    parameter int ROWS         = 6,
    parameter int HOLD_TIMEOUT = 500_000_000,
    parameter int TW           = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       my_turn,
    input  logic       mouse_valid,
    input  logic       l_click,
    input  logic [4:0] mouse_block_x,
    input  logic [2:0] mouse_block_y,
    input  logic       act_ready,
    output logic       act_valid,
    output logic [1:0] act_type,
    output logic [4:0] src_x,
    output logic [2:0] src_y,
    output logic [4:0] dst_x,
    output logic [2:0] dst_y,
    output logic       holding
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_SEL = 2'd1,
        HOLD      = 2'd2,
        ISSUE_FIN = 2'd3
    } state_t;

    localparam logic [1:0]    ACT_SELECT = 2'd0;
    localparam logic [1:0]    ACT_MOVE   = 2'd1;
    localparam logic [1:0]    ACT_CANCEL = 2'd2;
    localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t        state;
    logic          click_d;
    logic [TW-1:0] timer;

    logic click_rise;
    logic in_board;
    logic same_block;

    assign click_rise = l_click & ~click_d;
    assign in_board   = mouse_valid
                      & (int'(mouse_block_x) < COLS)
                      & (int'(mouse_block_y) < ROWS);
    assign same_block = (mouse_block_x == src_x) & (mouse_block_y == src_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            click_d   <= 1'b0;
            timer     <= '0;
            act_valid <= 1'b0;
            act_type  <= ACT_SELECT;
            src_x     <= '0;
            src_y     <= '0;
            dst_x     <= '0;
            dst_y     <= '0;
            holding   <= 1'b0;
        end else if (interboard_rst) begin
            state     <= IDLE;
            click_d   <= 1'b0;
            timer     <= '0;
            act_valid <= 1'b0;
            act_type  <= ACT_SELECT;
            src_x     <= '0;
            src_y     <= '0;
            dst_x     <= '0;
            dst_y     <= '0;
            holding   <= 1'b0;
        end else begin
            click_d <= l_click;
            case (state)
                IDLE: begin
                    if (click_rise && in_board && my_turn) begin
                        src_x     <= mouse_block_x;
                        src_y     <= mouse_block_y;
                        dst_x     <= '0;
                        dst_y     <= '0;
                        act_type  <= ACT_SELECT;
                        act_valid <= 1'b1;
                        holding   <= 1'b1;
                        state     <= ISSUE_SEL;
                    end
                end

                // Clicks arriving while an action is pending are dropped.
                ISSUE_SEL: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        timer     <= '0;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    if (timer != '1) begin
                        timer <= timer + TIMER_ONE;
                    end
                    // Turn loss and clicks on the source or off the board all cancel.
                    if (!my_turn || (click_rise && (!in_board || same_block))) begin
                        act_type  <= ACT_CANCEL;
                        dst_x     <= '0;
                        dst_y     <= '0;
                        act_valid <= 1'b1;
                        holding   <= 1'b0;
                        state     <= ISSUE_FIN;
                    end else if (click_rise) begin
                        act_type  <= ACT_MOVE;
                        dst_x     <= mouse_block_x;
                        dst_y     <= mouse_block_y;
                        act_valid <= 1'b1;
                        holding   <= 1'b0;
                        state     <= ISSUE_FIN;
                    end else if (timer == TIMER_LAST) begin
                        act_type  <= ACT_CANCEL;
                        dst_x     <= '0;
                        dst_y     <= '0;
                        act_valid <= 1'b1;
                        holding   <= 1'b0;
                        state     <= ISSUE_FIN;
                    end
                end

                ISSUE_FIN: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        act_type  <= ACT_SELECT;
                        dst_x     <= '0;
                        dst_y     <= '0;
                        timer     <= '0;
                        holding   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_action_ctrl.sv
// Bench for mouse_action_ctrl: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a behavioural model.
module tb_mouse_action_ctrl;

    localparam int COLS   = 18;
    localparam int ROWS   = 6;
    localparam int TO     = 16;
    localparam int P_IDLE = 0;
    localparam int P_SEL  = 1;
    localparam int P_HOLD = 2;
    localparam int P_FIN  = 3;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       interboard_rst = 1'b0;
    logic       my_turn        = 1'b0;
    logic       mouse_valid    = 1'b0;
    logic       l_click        = 1'b0;
    logic [4:0] mouse_block_x  = 5'd0;
    logic [2:0] mouse_block_y  = 3'd0;
    logic       act_ready      = 1'b0;

    logic       act_valid;
    logic [1:0] act_type;
    logic [4:0] src_x;
    logic [2:0] src_y;
    logic [4:0] dst_x;
    logic [2:0] dst_y;
    logic       holding;

    int total  = 0;
    int bad    = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of what the outputs must be.
    int m_phase;
    bit m_valid;
    int m_type;
    int m_src_x, m_src_y, m_dst_x, m_dst_y;
    bit m_holding;
    int m_hold_age;
    bit m_click_d;

    logic [19:0] got_vec;
    logic [19:0] want_vec;

    mouse_action_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS),
        .HOLD_TIMEOUT(TO),
        .TW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .interboard_rst(interboard_rst),
        .my_turn(my_turn),
        .mouse_valid(mouse_valid),
        .l_click(l_click),
        .mouse_block_x(mouse_block_x),
        .mouse_block_y(mouse_block_y),
        .act_ready(act_ready),
        .act_valid(act_valid),
        .act_type(act_type),
        .src_x(src_x),
        .src_y(src_y),
        .dst_x(dst_x),
        .dst_y(dst_y),
        .holding(holding)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_phase    = P_IDLE;
        m_valid    = 1'b0;
        m_type     = 0;
        m_src_x    = 0;
        m_src_y    = 0;
        m_dst_x    = 0;
        m_dst_y    = 0;
        m_holding  = 1'b0;
        m_hold_age = 0;
        m_click_d  = 1'b0;
    endfunction

    function automatic void model_finish(int kind, int dx, int dy);
        m_type  = kind;
        m_dst_x = dx;
        m_dst_y = dy;
        m_valid = 1'b1;
        m_phase = P_FIN;
    endfunction

    function automatic void model_step();
        bit rise, inb, same;
        int bx, by;
        if (rst || interboard_rst) begin
            model_reset();
            return;
        end
        bx   = int'(mouse_block_x);
        by   = int'(mouse_block_y);
        rise = l_click && !m_click_d;
        inb  = mouse_valid && (bx < COLS) && (by < ROWS);
        same = (bx == m_src_x) && (by == m_src_y);
        m_click_d = l_click;
        case (m_phase)
            P_IDLE: if (rise && inb && my_turn) begin
                m_src_x = bx;
                m_src_y = by;
                m_dst_x = 0;
                m_dst_y = 0;
                m_type  = 0;
                m_valid = 1'b1;
                m_phase = P_SEL;
            end
            P_SEL: if (act_ready) begin
                m_valid    = 1'b0;
                m_hold_age = 0;
                m_phase    = P_HOLD;
            end
            P_HOLD: begin
                if (!my_turn || (rise && (!inb || same))) model_finish(2, 0, 0);
                else if (rise) model_finish(1, bx, by);
                else if (m_hold_age == TO - 1) model_finish(2, 0, 0);
                m_hold_age++;
            end
            P_FIN: if (act_ready) begin
                m_valid = 1'b0;
                m_type  = 0;
                m_dst_x = 0;
                m_dst_y = 0;
                m_phase = P_IDLE;
            end
            default: ;
        endcase
        m_holding = (m_phase == P_SEL) || (m_phase == P_HOLD);
    endfunction

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            got_vec  = {act_valid, act_type, src_x, src_y, dst_x, dst_y, holding};
            want_vec = {m_valid, 2'(m_type), 5'(m_src_x), 3'(m_src_y),
                        5'(m_dst_x), 3'(m_dst_y), m_holding};
            total++;
            if (got_vec !== want_vec) begin
                bad++;
                $display("FAIL outputs t=%0t got v=%0d type=%0d src=(%0d,%0d) dst=(%0d,%0d) hold=%0d required v=%0d type=%0d src=(%0d,%0d) dst=(%0d,%0d) hold=%0d",
                         $time, act_valid, act_type, src_x, src_y, dst_x, dst_y, holding,
                         m_valid, m_type, m_src_x, m_src_y, m_dst_x, m_dst_y, m_holding);
            end
        end
    end

    task automatic expect_eq(string name, int got, int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic click_at(int x, int y);
        mouse_valid   = 1'b1;
        mouse_block_x = 5'(x);
        mouse_block_y = 3'(y);
        l_click       = 1'b1;
        tick();
        l_click       = 1'b0;
    endtask

    task automatic ack();
        act_ready = 1'b1;
        tick();
        act_ready = 1'b0;
    endtask

    task automatic select_and_hold(int x, int y);
        click_at(x, y);
        ack();
    endtask

    int sel_count;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        expect_eq("reset_valid", int'(act_valid), 0);
        expect_eq("reset_holding", int'(holding), 0);
        expect_eq("reset_src_x", int'(src_x), 0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Basic move
        my_turn = 1'b1;
        click_at(3, 2);
        expect_eq("sel_valid", int'(act_valid), 1);
        expect_eq("sel_type", int'(act_type), 0);
        expect_eq("sel_src_x", int'(src_x), 3);
        expect_eq("sel_src_y", int'(src_y), 2);
        expect_eq("sel_holding", int'(holding), 1);
        repeat (3) tick();
        expect_eq("sel_wait_valid", int'(act_valid), 1);
        ack();
        expect_eq("sel_acked_valid", int'(act_valid), 0);
        expect_eq("hold_holding", int'(holding), 1);
        click_at(7, 5);
        expect_eq("move_type", int'(act_type), 1);
        expect_eq("move_dst_x", int'(dst_x), 7);
        expect_eq("move_dst_y", int'(dst_y), 5);
        expect_eq("move_src_x", int'(src_x), 3);
        expect_eq("move_holding", int'(holding), 0);
        ack();
        expect_eq("idle_valid", int'(act_valid), 0);
        expect_eq("idle_dst_x", int'(dst_x), 0);
        expect_eq("idle_src_kept", int'(src_x), 3);

        // Same-block and off-board cancels
        select_and_hold(0, 0);
        click_at(0, 0);
        expect_eq("same_cancel_type", int'(act_type), 2);
        expect_eq("same_cancel_valid", int'(act_valid), 1);
        ack();
        select_and_hold(0, 0);
        mouse_valid = 1'b0;
        l_click     = 1'b1;
        tick();
        l_click     = 1'b0;
        expect_eq("offmouse_cancel_type", int'(act_type), 2);
        expect_eq("offmouse_cancel_dst", int'(dst_x), 0);
        ack();
        select_and_hold(0, 0);
        click_at(18, 1);
        expect_eq("col18_cancel_type", int'(act_type), 2);
        expect_eq("col18_cancel_dst", int'(dst_x), 0);
        ack();

        // Not our turn: clicks ignored
        my_turn = 1'b0;
        click_at(4, 4);
        repeat (3) tick();
        expect_eq("noturn_valid", int'(act_valid), 0);
        expect_eq("noturn_holding", int'(holding), 0);
        my_turn = 1'b1;

        // Held button yields one SELECT only
        mouse_valid   = 1'b1;
        mouse_block_x = 5'd5;
        mouse_block_y = 3'd1;
        l_click       = 1'b1;
        act_ready     = 1'b1;
        sel_count     = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (act_valid && act_type == 2'd0) sel_count++;
        end
        act_ready = 1'b0;
        l_click   = 1'b0;
        tick();
        expect_eq("held_select_count", sel_count, 1);
        expect_eq("held_end_valid", int'(act_valid), 0);

        // Click during ISSUE_SEL is dropped, then timeout
        click_at(2, 3);
        click_at(9, 4);
        expect_eq("drop_src_x", int'(src_x), 2);
        expect_eq("drop_src_y", int'(src_y), 3);
        expect_eq("drop_type", int'(act_type), 0);
        ack();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            expect_eq("timeout_early", int'(act_valid), 0);
        end
        tick();
        expect_eq("timeout_valid", int'(act_valid), 1);
        expect_eq("timeout_type", int'(act_type), 2);

        // Backpressure: 50 cycles of noise, no ack
        for (int i = 0; i < 50; i++) begin
            my_turn       = 1'($urandom_range(0, 1));
            mouse_valid   = 1'($urandom_range(0, 1));
            mouse_block_x = 5'($urandom_range(0, 20));
            mouse_block_y = 3'($urandom_range(0, 7));
            l_click       = 1'($urandom_range(0, 1));
            tick();
        end
        expect_eq("bp_valid", int'(act_valid), 1);
        expect_eq("bp_type", int'(act_type), 2);
        expect_eq("bp_src_x", int'(src_x), 2);
        my_turn = 1'b1;
        l_click = 1'b0;
        ack();
        tick();

        // Turn loss in HOLD
        select_and_hold(6, 0);
        tick();
        my_turn = 1'b0;
        tick();
        expect_eq("turnloss_valid", int'(act_valid), 1);
        expect_eq("turnloss_type", int'(act_type), 2);
        my_turn = 1'b1;
        ack();

        // Turn loss in ISSUE_SEL: handshake completes, then CANCEL
        click_at(1, 1);
        my_turn = 1'b0;
        ack();
        expect_eq("sel_turnloss_holding", int'(holding), 1);
        tick();
        expect_eq("sel_turnloss_type", int'(act_type), 2);
        my_turn = 1'b1;
        ack();

        // interboard_rst during ISSUE_FIN
        select_and_hold(4, 2);
        click_at(8, 3);
        interboard_rst = 1'b1;
        tick();
        interboard_rst = 1'b0;
        expect_eq("ibrst_valid", int'(act_valid), 0);
        expect_eq("ibrst_src_x", int'(src_x), 0);
        expect_eq("ibrst_dst_x", int'(dst_x), 0);

        // Asynchronous rst mid-HOLD
        select_and_hold(10, 5);
        tick();
        expect_eq("prerst_holding", int'(holding), 1);
        #2 rst = 1'b1;
        #1;
        expect_eq("arst_holding", int'(holding), 0);
        expect_eq("arst_src_x", int'(src_x), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            my_turn     = ($urandom_range(0, 9) != 0);
            mouse_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                mouse_block_x = 5'(m_src_x);
                mouse_block_y = 3'(m_src_y);
            end else begin
                mouse_block_x = 5'($urandom_range(0, 20));
                mouse_block_y = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2) == 0) l_click = ~l_click;
            act_ready      = 1'($urandom_range(0, 1));
            interboard_rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        interboard_rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_action_ctrl.md
Name: mouse_action_ctrl

Overview:
Sequences raw mouse-interface outputs (click, validity, block coordinates) into discrete game actions: select a source block, then move to or cancel at a destination block. Sits between the mouse interface top and the game-state logic. Hands actions off over a valid/ready handshake. Gated by turn ownership, with a hold timeout.

Parameters:
COLS, 18, number of valid block columns; block_x must be less than COLS.
ROWS, 6, number of valid block rows; block_y must be less than ROWS.
HOLD_TIMEOUT, 500_000_000, cycles in HOLD without a new click before an automatic CANCEL (5 s at 100 MHz).
TW, 29, width of the timeout counter; must satisfy 2^TW > HOLD_TIMEOUT.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
interboard_rst  input  1  synchronous clear from the peer board, active-high
my_turn  input  1  high while this board owns the turn
mouse_valid  input  1  mouse is over some block
l_click  input  1  left button level
mouse_block_x  input  5  hovered block column
mouse_block_y  input  3  hovered block row
act_ready  input  1  game logic accepts the action
act_valid  output  1  action pending
act_type  output  2  0=SELECT, 1=MOVE, 2=CANCEL, 3 reserved
src_x  output  5  latched source column
src_y  output  3  latched source row
dst_x  output  5  latched destination column (MOVE only, else 0)
dst_y  output  3  latched destination row (MOVE only, else 0)
holding  output  1  high in HOLD and in ISSUE_SEL

Behaviour:
- Reset (rst asynchronous, or interboard_rst on a clk edge): state IDLE. All outputs 0, timer 0, click_d 0. interboard_rst has priority over all other events in that cycle.
- Click detection: click_d registered from l_click. click_rise = l_click & ~click_d. Only rising edges act; a held button never retriggers.
- in_board = mouse_valid & (mouse_block_x < COLS) & (mouse_block_y < ROWS).
- IDLE:
  - click_rise & in_board & my_turn: latch src = block, act_type = SELECT, act_valid = 1, go ISSUE_SEL. act_valid rises the cycle after the edge.
  - Any other click: ignored.
- ISSUE_SEL: hold act_valid, act_type, src and dst stable until act_ready. In the act_ready cycle: act_valid goes 0 next cycle, timer clears, go HOLD. Clicks in this state are dropped.
- HOLD: timer increments each cycle, saturating.
  - Priority 1, my_turn = 0: CANCEL.
  - Priority 2, click_rise & ~in_board: CANCEL.
  - Priority 3, click_rise & in_board & block == src: CANCEL.
  - Priority 4, click_rise & in_board & block != src: MOVE, latch dst.
  - Priority 5, timer == HOLD_TIMEOUT-1: CANCEL.
  - Each action asserts act_valid and goes ISSUE_FIN.
- ISSUE_FIN: same handshake as ISSUE_SEL. On act_ready go IDLE next cycle; act_valid, act_type, dst and timer clear, src retained. Clicks dropped.
- Loss of my_turn during ISSUE_SEL or ISSUE_FIN does not abort the handshake. If lost during ISSUE_SEL, HOLD issues CANCEL on its first cycle.
- act_valid never drops without act_ready; there is no timeout on the handshake.
- act_ready while act_valid = 0 is ignored.
- All outputs are registered; no combinational path from inputs to outputs.
- Encode states in 2 bits: IDLE, ISSUE_SEL, HOLD, ISSUE_FIN.

Test Plan:
- Basic move: my_turn = 1, click at (3,2), ack after 4 cycles, then click at (7,5) → SELECT with src=(3,2), then MOVE with src=(3,2), dst=(7,5). act_valid is high exactly until the ack cycle. State returns to IDLE.
- Same-block and off-board cancels: select (0,0), then click (0,0) → CANCEL. Select (0,0), then click with mouse_valid=0 or block_x=18 → CANCEL, dst=(0,0).
- Gating: my_turn = 0 → click ignored, act_valid stays 0. Holding l_click high for 1000 cycles → only one SELECT. A click during ISSUE_SEL while act_ready is held 0 → no state change.
- Timeout: HOLD_TIMEOUT overridden to 16, select, no clicks → CANCEL with act_valid rising exactly 16 cycles after HOLD entry.
- Turn loss and backpressure: in HOLD, drop my_turn → CANCEL next cycle. Keep act_ready low for 50 cycles → outputs stable throughout.
- Resets: interboard_rst pulse in ISSUE_FIN → IDLE with all outputs 0 next cycle. rst asserted mid-HOLD → outputs 0 immediately, without waiting for a clk edge.
